// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin share of one 32-bit integer ALU between two requesters
//            with a registered, backpressured result port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_req0_valid,
    output logic        o_req0_ready,
    input  logic [31:0] i_req0_lhs,
    input  logic [31:0] i_req0_rhs,
    input  logic [3:0]  i_req0_function,

    input  logic        i_req1_valid,
    output logic        o_req1_ready,
    input  logic [31:0] i_req1_lhs,
    input  logic [31:0] i_req1_rhs,
    input  logic [3:0]  i_req1_function,

    output logic        o_result_valid,
    input  logic        i_result_ready,
    output logic [31:0] o_result,
    output logic        o_result_owner,
    output logic        o_result_illegal
);

    localparam logic [3:0] c_FN_ADD  = 4'b0000;
    localparam logic [3:0] c_FN_SUB  = 4'b1000;
    localparam logic [3:0] c_FN_SLL  = 4'b0001;
    localparam logic [3:0] c_FN_SLT  = 4'b0010;
    localparam logic [3:0] c_FN_SLTU = 4'b0011;
    localparam logic [3:0] c_FN_XOR  = 4'b0100;
    localparam logic [3:0] c_FN_SRL  = 4'b0101;
    localparam logic [3:0] c_FN_SRA  = 4'b1101;
    localparam logic [3:0] c_FN_OR   = 4'b0110;
    localparam logic [3:0] c_FN_AND  = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_prio;
    logic [31:0] r_op_lhs;
    logic [31:0] r_op_rhs;
    logic [3:0]  r_op_func;
    logic        r_op_owner;

    logic [31:0] r_result;
    logic        r_result_owner;
    logic        r_result_illegal;

    logic        w_window;
    logic        w_any_valid;
    logic        w_grant_sel;
    logic        w_accept;

    logic [31:0] w_alu_result;
    logic        w_alu_illegal;
    logic [4:0]  w_shamt;

    // ------------------------------------------------------------------------
    // Arbitration: the pointer only matters when both requesters contend.
    // ------------------------------------------------------------------------
    assign w_window    = (r_state == ST_IDLE) || ((r_state == ST_DONE) && i_result_ready);
    assign w_any_valid = i_req0_valid | i_req1_valid;
    assign w_grant_sel = (i_req0_valid && i_req1_valid) ? r_prio : i_req1_valid;
    assign w_accept    = w_window & w_any_valid;

    assign o_req0_ready = w_accept & ~w_grant_sel;
    assign o_req1_ready = w_accept &  w_grant_sel;

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (i_result_ready) begin
                    w_state_nxt = w_accept ? ST_EXEC : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Operand capture and round-robin pointer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio     <= 1'b0;
            r_op_lhs   <= 32'd0;
            r_op_rhs   <= 32'd0;
            r_op_func  <= 4'd0;
            r_op_owner <= 1'b0;
        end else if (w_accept) begin
            r_prio     <= ~w_grant_sel;
            r_op_owner <= w_grant_sel;
            r_op_lhs   <= w_grant_sel ? i_req1_lhs      : i_req0_lhs;
            r_op_rhs   <= w_grant_sel ? i_req1_rhs      : i_req0_rhs;
            r_op_func  <= w_grant_sel ? i_req1_function : i_req0_function;
        end
    end

    // ------------------------------------------------------------------------
    // ALU: fed only from the captured operand registers.
    // ------------------------------------------------------------------------
    assign w_shamt = r_op_rhs[4:0];

    always_comb begin
        w_alu_result  = 32'd0;
        w_alu_illegal = 1'b0;
        case (r_op_func)
            c_FN_ADD:  w_alu_result = r_op_lhs + r_op_rhs;
            c_FN_SUB:  w_alu_result = r_op_lhs - r_op_rhs;
            c_FN_SLL:  w_alu_result = r_op_lhs << w_shamt;
            c_FN_SLT:  w_alu_result = {31'd0, ($signed(r_op_lhs) < $signed(r_op_rhs))};
            c_FN_SLTU: w_alu_result = {31'd0, (r_op_lhs < r_op_rhs)};
            c_FN_XOR:  w_alu_result = r_op_lhs ^ r_op_rhs;
            c_FN_SRL:  w_alu_result = r_op_lhs >> w_shamt;
            c_FN_SRA:  w_alu_result = $unsigned($signed(r_op_lhs) >>> w_shamt);
            c_FN_OR:   w_alu_result = r_op_lhs | r_op_rhs;
            c_FN_AND:  w_alu_result = r_op_lhs & r_op_rhs;
            default: begin
                w_alu_result  = 32'd0;
                w_alu_illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Result register: loads only on the EXEC->DONE edge, so it holds steady
    // for the whole time the consumer stalls.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result         <= 32'd0;
            r_result_owner   <= 1'b0;
            r_result_illegal <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_result         <= w_alu_result;
            r_result_owner   <= r_op_owner;
            r_result_illegal <= w_alu_illegal;
        end
    end

    assign o_result_valid   = (r_state == ST_DONE);
    assign o_result         = r_result;
    assign o_result_owner   = r_result_owner;
    assign o_result_illegal = r_result_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Directed self-checking bench for alu_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        r_req0_valid;
    logic        w_req0_ready;
    logic [31:0] r_req0_lhs;
    logic [31:0] r_req0_rhs;
    logic [3:0]  r_req0_function;
    logic        r_req1_valid;
    logic        w_req1_ready;
    logic [31:0] r_req1_lhs;
    logic [31:0] r_req1_rhs;
    logic [3:0]  r_req1_function;
    logic        w_result_valid;
    logic        r_result_ready;
    logic [31:0] w_result;
    logic        w_result_owner;
    logic        w_result_illegal;

    int n_tests;
    int n_fail;

    alu_arbiter u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_req0_valid     (r_req0_valid),
        .o_req0_ready     (w_req0_ready),
        .i_req0_lhs       (r_req0_lhs),
        .i_req0_rhs       (r_req0_rhs),
        .i_req0_function  (r_req0_function),
        .i_req1_valid     (r_req1_valid),
        .o_req1_ready     (w_req1_ready),
        .i_req1_lhs       (r_req1_lhs),
        .i_req1_rhs       (r_req1_rhs),
        .i_req1_function  (r_req1_function),
        .o_result_valid   (w_result_valid),
        .i_result_ready   (r_result_ready),
        .o_result         (w_result),
        .o_result_owner   (w_result_owner),
        .o_result_illegal (w_result_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One isolated operation from a single requester, consumer always ready.
    task automatic run_op(input string tag, input logic who, input logic [31:0] lhs,
                          input logic [31:0] rhs, input logic [3:0] fn,
                          input logic [31:0] exp_res, input logic exp_ill);
        @(negedge clk);
        r_result_ready = 1'b1;
        if (who) begin
            r_req1_valid = 1'b1; r_req1_lhs = lhs; r_req1_rhs = rhs; r_req1_function = fn;
        end else begin
            r_req0_valid = 1'b1; r_req0_lhs = lhs; r_req0_rhs = rhs; r_req0_function = fn;
        end
        #1;
        check({tag, "_ready"}, {31'd0, who ? w_req1_ready : w_req0_ready}, 32'd1);
        @(posedge clk); #1;
        r_req0_valid = 1'b0;
        r_req1_valid = 1'b0;
        check({tag, "_exec_rv"}, {31'd0, w_result_valid}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_rv"},      {31'd0, w_result_valid},   32'd1);
        check({tag, "_result"},  w_result,                  exp_res);
        check({tag, "_owner"},   {31'd0, w_result_owner},   {31'd0, who});
        check({tag, "_illegal"}, {31'd0, w_result_illegal}, {31'd0, exp_ill});
        @(posedge clk); #1;
        check({tag, "_idle_rv"}, {31'd0, w_result_valid}, 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        r_req0_valid = 1'b0; r_req0_lhs = '0; r_req0_rhs = '0; r_req0_function = '0;
        r_req1_valid = 1'b0; r_req1_lhs = '0; r_req1_rhs = '0; r_req1_function = '0;
        r_result_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rv",      {31'd0, w_result_valid},   32'd0);
        check("rst_result",  w_result,                  32'd0);
        check("rst_owner",   {31'd0, w_result_owner},   32'd0);
        check("rst_illegal", {31'd0, w_result_illegal}, 32'd0);
        check("rst_ready",   {30'd0, w_req1_ready, w_req0_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Contention: grants alternate starting with Req0
        @(negedge clk);
        r_req0_valid = 1'b1; r_req0_lhs = 32'hF0F0F0F0; r_req0_rhs = 32'hFFFFFFFF; r_req0_function = 4'b0100;
        r_req1_valid = 1'b1; r_req1_lhs = 32'h80000000; r_req1_rhs = 32'h00000024; r_req1_function = 4'b1101;
        #1;
        check("cont_first_ready", {30'd0, w_req1_ready, w_req0_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("cont_exec_rv", {31'd0, w_result_valid}, 32'd0);
            check("cont_exec_ready", {30'd0, w_req1_ready, w_req0_ready}, 32'd0);
            @(posedge clk); #1;
            check("cont_rv", {31'd0, w_result_valid}, 32'd1);
            check("cont_owner", {31'd0, w_result_owner}, (k % 2));
            check("cont_result", w_result, (k % 2 == 0) ? 32'h0F0F0F0F : 32'hF8000000);
            check("cont_next_ready", {30'd0, w_req1_ready, w_req0_ready},
                  (k % 2 == 0) ? 32'd2 : 32'd1);
            if (k == 3) begin
                r_req0_valid = 1'b0;
                r_req1_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        check("cont_idle_rv", {31'd0, w_result_valid}, 32'd0);

        // Single op: add wraps into the sign bit
        run_op("add", 1'b0, 32'h7FFFFFFF, 32'h00000001, 4'b0000, 32'h80000000, 1'b0);

        // Backpressure: Req1 waits while the result is stalled
        @(negedge clk);
        r_req0_valid = 1'b1; r_req0_lhs = 32'd1; r_req0_rhs = 32'd2; r_req0_function = 4'b0000;
        @(posedge clk); #1;
        r_req0_valid = 1'b0;
        r_req1_valid = 1'b1; r_req1_lhs = 32'hFFFFFFFF; r_req1_rhs = 32'd1; r_req1_function = 4'b0010;
        r_result_ready = 1'b0;
        check("bp_exec_ready1", {31'd0, w_req1_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_rv",     {31'd0, w_result_valid}, 32'd1);
            check("bp_result", w_result,                32'd3);
            check("bp_ready1", {31'd0, w_req1_ready},   32'd0);
        end
        r_result_ready = 1'b1;
        #1;
        check("bp_release_ready1", {31'd0, w_req1_ready}, 32'd1);
        @(posedge clk); #1;
        r_req1_valid = 1'b0;
        check("bp_exec_rv", {31'd0, w_result_valid}, 32'd0);
        @(posedge clk); #1;
        check("bp_slt_rv",     {31'd0, w_result_valid}, 32'd1);
        check("bp_slt_result", w_result,                32'd1);
        check("bp_slt_owner",  {31'd0, w_result_owner}, 32'd1);
        @(posedge clk); #1;

        // Function coverage
        run_op("sltu",    1'b0, 32'hFFFFFFFF, 32'd1,        4'b0011, 32'd0,         1'b0);
        run_op("sub",     1'b1, 32'd0,        32'd1,        4'b1000, 32'hFFFFFFFF,  1'b0);
        run_op("illegal", 1'b0, 32'd5,        32'd3,        4'b1111, 32'd0,         1'b1);
        run_op("sll",     1'b1, 32'd1,        32'h00000021, 4'b0001, 32'd2,         1'b0);
        run_op("srl",     1'b0, 32'h80000000, 32'd4,        4'b0101, 32'h08000000,  1'b0);
        run_op("and",     1'b0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0111, 32'h0F000F00,  1'b0);
        run_op("or",      1'b1, 32'hFF00FF00, 32'h0FF00FF0, 4'b0110, 32'hFFF0FFF0,  1'b0);

        // Reset during EXEC aborts the op and clears the held result
        @(negedge clk);
        r_req0_valid = 1'b1; r_req0_lhs = 32'd10; r_req0_rhs = 32'd20; r_req0_function = 4'b0000;
        @(posedge clk); #1;
        r_req0_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rv",      {31'd0, w_result_valid},   32'd0);
        check("mid_rst_result",  w_result,                  32'd0);
        check("mid_rst_owner",   {31'd0, w_result_owner},   32'd0);
        check("mid_rst_illegal", {31'd0, w_result_illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_rv", {31'd0, w_result_valid}, 32'd0);
        end
        @(negedge clk);
        r_req0_valid = 1'b1; r_req0_lhs = 32'd4; r_req0_rhs = 32'd5; r_req0_function = 4'b0100;
        r_req1_valid = 1'b1; r_req1_lhs = 32'd4; r_req1_rhs = 32'd5; r_req1_function = 4'b0000;
        #1;
        check("post_rst_prio", {30'd0, w_req1_ready, w_req0_ready}, 32'd1);
        @(posedge clk); #1;
        r_req0_valid = 1'b0;
        r_req1_valid = 1'b0;
        @(posedge clk); #1;
        check("post_rst_rv2",    {31'd0, w_result_valid}, 32'd1);
        check("post_rst_result", w_result,                32'd1);
        check("post_rst_owner",  {31'd0, w_result_owner}, 32'd0);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
